// File: rtl/pssi_pkg.sv
// Shared types and constants for the PSSI transmit controller.
// Byte geometry and default bus timing live here so the RTL and the bench agree.
package pssi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } pssi_state_e;

    localparam int PSSI_BYTES   = 4;
    localparam int PSSI_W       = 8;
    localparam int PSSI_WORD_W  = PSSI_BYTES * PSSI_W;
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_IDLE_GAP = 2;

    // Byte idx of a word, idx 3 being the most significant byte.
    function automatic logic [PSSI_W-1:0] pssi_byte(input logic [PSSI_WORD_W-1:0] word,
                                                    input logic [1:0]             idx);
        return word[{idx, 3'b000} +: PSSI_W];
    endfunction

endpackage

// File: rtl/pssi_tx_ctrl_if.sv
// Requester handshakes and PSSI pin bundle of the transmit controller.
// master = the requester/board side, slave = the controller.
interface pssi_tx_ctrl_if;
    import pssi_pkg::*;

    logic                   enable_i;
    logic                   req0_valid_i;
    logic [PSSI_WORD_W-1:0] req0_data_i;
    logic                   req0_ready_o;
    logic                   req1_valid_i;
    logic [PSSI_WORD_W-1:0] req1_data_i;
    logic                   req1_ready_o;
    logic                   pssi_clk_o;
    logic                   pssi_de_n_o;
    logic [PSSI_W-1:0]      pssi_data_o;
    logic                   busy_o;
    logic                   last_grant_o;
    logic [15:0]            word_cnt_o;

    modport master (
        output enable_i, req0_valid_i, req0_data_i, req1_valid_i, req1_data_i,
        input  req0_ready_o, req1_ready_o, pssi_clk_o, pssi_de_n_o, pssi_data_o,
               busy_o, last_grant_o, word_cnt_o
    );

    modport slave (
        input  enable_i, req0_valid_i, req0_data_i, req1_valid_i, req1_data_i,
        output req0_ready_o, req1_ready_o, pssi_clk_o, pssi_de_n_o, pssi_data_o,
               busy_o, last_grant_o, word_cnt_o
    );

endinterface

// File: rtl/pssi_clk_gen.sv
// Free-running divider: PSSI clock low for the first half of each period,
// tick on the last core cycle so that updates land on the PSSI falling edge.
module pssi_clk_gen
    import pssi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic pssi_clk_o,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;
    logic          pssi_clk_q;

    // Next divider count with wrap at the end of the period.
    always_comb begin
        div_cnt_d = div_cnt_q + CW'(1);
        if (div_cnt_q == CW'(CLK_DIV - 1)) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + CW'(1);
        end
    end

    // The clock register tracks the count it is loaded alongside, so it falls with the wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q  <= '0;
            pssi_clk_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            pssi_clk_q <= (div_cnt_d >= CW'(CLK_DIV / 2));
        end
    end

    assign pssi_clk_o = pssi_clk_q;
    assign tick_o     = (div_cnt_q == CW'(CLK_DIV - 1));

endmodule

// File: rtl/pssi_tx_ctrl.sv
// Arbitrates two 32-bit word sources and serialises the granted word MSB byte
// first onto the 8-bit PSSI bus, with DE low for the four byte periods.
module pssi_tx_ctrl
    import pssi_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int IDLE_GAP = DEF_IDLE_GAP
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pssi_tx_ctrl_if.slave  bus
);

    localparam int GW = (IDLE_GAP > 2) ? $clog2(IDLE_GAP - 1) : 1;

    pssi_state_e            state_q;
    logic [1:0]             byte_idx_q;
    logic [PSSI_WORD_W-1:0] word_q;
    logic [GW-1:0]          gap_cnt_q;
    logic                   de_n_q;
    logic [PSSI_W-1:0]      data_q;
    logic                   busy_q;
    logic                   last_grant_q;
    logic [15:0]            word_cnt_q;

    logic                   tick_s;
    logic                   pssi_clk_s;
    logic                   idle_tick_s;
    logic                   grant1_s;
    logic                   grant0_s;
    logic                   ready0_s;
    logic                   ready1_s;
    logic [PSSI_WORD_W-1:0] word_sel_s;

    pssi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pssi_clk_o (pssi_clk_s),
        .tick_o     (tick_s)
    );

    // When both request, the one not served last time wins.
    assign grant1_s    = bus.req1_valid_i & (~bus.req0_valid_i | ~last_grant_q);
    assign grant0_s    = bus.req0_valid_i & ~grant1_s;
    assign idle_tick_s = (state_q == IDLE) & tick_s & bus.enable_i;
    assign ready0_s    = idle_tick_s & grant0_s;
    assign ready1_s    = idle_tick_s & grant1_s;
    assign word_sel_s  = grant1_s ? bus.req1_data_i : bus.req0_data_i;

    // The IDLE period that ends in the accepting tick is the final gap period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            byte_idx_q   <= 2'd0;
            word_q       <= '0;
            gap_cnt_q    <= '0;
            de_n_q       <= 1'b1;
            data_q       <= 8'h00;
            busy_q       <= 1'b0;
            last_grant_q <= 1'b1;
            word_cnt_q   <= 16'h0000;
        end else if (tick_s) begin
            case (state_q)
                IDLE: begin
                    if (ready0_s | ready1_s) begin
                        state_q      <= SHIFT;
                        byte_idx_q   <= 2'd3;
                        word_q       <= word_sel_s;
                        last_grant_q <= ready1_s;
                        busy_q       <= 1'b1;
                        de_n_q       <= 1'b0;
                        data_q       <= pssi_byte(word_sel_s, 2'd3);
                    end
                end
                SHIFT: begin
                    if (byte_idx_q == 2'd0) begin
                        word_cnt_q <= word_cnt_q + 16'd1;
                        de_n_q     <= 1'b1;
                        data_q     <= 8'h00;
                        if (IDLE_GAP == 1) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= GAP;
                            gap_cnt_q <= GW'(IDLE_GAP - 2);
                        end
                    end else begin
                        byte_idx_q <= byte_idx_q - 2'd1;
                        data_q     <= pssi_byte(word_q, byte_idx_q - 2'd1);
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GW'(0)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    de_n_q  <= 1'b1;
                    data_q  <= 8'h00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ready_o = ready0_s;
    assign bus.req1_ready_o = ready1_s;
    assign bus.pssi_clk_o   = pssi_clk_s;
    assign bus.pssi_de_n_o  = de_n_q;
    assign bus.pssi_data_o  = data_q;
    assign bus.busy_o       = busy_q;
    assign bus.last_grant_o = last_grant_q;
    assign bus.word_cnt_o   = word_cnt_q;

endmodule

// File: tb/tb_pssi_tx_ctrl.sv
// Directed bench for pssi_tx_ctrl: a table of word transfers plus hand-written
// enable, reset, wrap and CLK_DIV=2/IDLE_GAP=1 sequences.
module tb_pssi_tx_ctrl;
    import pssi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pssi_tx_ctrl_if bus();
    pssi_tx_ctrl_if bus2();

    pssi_tx_ctrl #(.CLK_DIV(4), .IDLE_GAP(2)) dut  (.clk_i(clk), .rst_i(rst), .bus(bus));
    pssi_tx_ctrl #(.CLK_DIV(2), .IDLE_GAP(1)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned last_acc = 0;
    int          sel = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic        m_r0, m_r1, m_pclk, m_de_n, m_busy, m_last;
    logic [7:0]  m_data;
    logic [15:0] m_cnt;

    always_comb begin
        if (sel == 0) begin
            m_r0 = bus.req0_ready_o;   m_r1 = bus.req1_ready_o;   m_pclk = bus.pssi_clk_o;
            m_de_n = bus.pssi_de_n_o;  m_busy = bus.busy_o;       m_last = bus.last_grant_o;
            m_data = bus.pssi_data_o;  m_cnt = bus.word_cnt_o;
        end else begin
            m_r0 = bus2.req0_ready_o;  m_r1 = bus2.req1_ready_o;  m_pclk = bus2.pssi_clk_o;
            m_de_n = bus2.pssi_de_n_o; m_busy = bus2.busy_o;      m_last = bus2.last_grant_o;
            m_data = bus2.pssi_data_o; m_cnt = bus2.word_cnt_o;
        end
    end

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        hold;
        logic        exp_g;
        logic [31:0] exp_w;
        logic [15:0] exp_cnt;
        logic        chk_space;
    } vec_t;

    vec_t vecs[7];
    vec_t sv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive_v(input logic v0, input logic v1, input logic [31:0] d0, input logic [31:0] d1);
        if (sel == 0) begin
            bus.req0_valid_i = v0;  bus.req1_valid_i = v1;
            bus.req0_data_i  = d0;  bus.req1_data_i  = d1;
        end else begin
            bus2.req0_valid_i = v0; bus2.req1_valid_i = v1;
            bus2.req0_data_i  = d0; bus2.req1_data_i  = d1;
        end
        #1;
    endtask

    task automatic drive_en(input logic en);
        if (sel == 0) bus.enable_i = en;
        else          bus2.enable_i = en;
        #1;
    endtask

    task automatic wait_accept(output bit got);
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (m_r0 || m_r1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_quiet(input string name, input int n);
        bit ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (m_r0 || m_r1 || m_de_n !== 1'b1 || m_data !== 8'h00) ok = 1'b0;
            @(negedge clk);
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    // Accept, four byte periods, then the gap; leaves the bench on the last gap cycle.
    task automatic send_word(input vec_t v, input int drop_byte);
        bit got;
        bit ok;
        int div = (sel == 0) ? 4 : 2;
        int gap = (sel == 0) ? 2 : 1;
        drive_v(v.v0, v.v1, v.d0, v.d1);
        wait_accept(got);
        if (!got) return;
        chk("ready_exclusive", 32'(m_r0 & m_r1), 32'd0);
        chk("grant", 32'(m_r1), 32'(v.exp_g));
        if (v.chk_space) chk("word_spacing", cyc - last_acc, 32'((4 + gap) * div));
        last_acc = cyc;
        @(posedge clk);
        #1;
        if (!v.hold) drive_v(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("busy_after_accept", 32'(m_busy), 32'd1);
        chk("last_grant", 32'(m_last), 32'(v.exp_g));
        for (int b = 3; b >= 0; b--) begin
            ok = 1'b1;
            for (int k = 0; k < div; k++) begin
                if (b == drop_byte && k == 0) drive_en(1'b0);
                if (m_de_n !== 1'b0 || m_data !== v.exp_w[8*b +: 8] || m_pclk !== (k >= div / 2)) ok = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("byte%0d_stable_%0h", b, v.exp_w[8*b +: 8]), 32'(ok), 32'd1);
        end
        chk("word_cnt", 32'(m_cnt), 32'(v.exp_cnt));
        ok = 1'b1;
        for (int k = 0; k < gap * div; k++) begin
            if (m_de_n !== 1'b1 || m_data !== 8'h00) ok = 1'b0;
            if (k != gap * div - 1) @(negedge clk);
        end
        chk("gap_idle", 32'(ok), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        //          v0    v1    d0            d1            hold  g     word          cnt     space
        vecs[0] = '{1'b1, 1'b0, 32'hA1B2C3D4, 32'h00000000, 1'b0, 1'b0, 32'hA1B2C3D4, 16'd1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h11111111, 32'h22222222, 1'b1, 1'b1, 32'h22222222, 16'd2, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 32'h11111111, 32'h22222222, 1'b1, 1'b0, 32'h11111111, 16'd3, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 32'h11111111, 32'h22222222, 1'b1, 1'b1, 32'h22222222, 16'd4, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 32'h11111111, 16'd5, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'h00000000, 32'h5A5AA5A5, 1'b0, 1'b1, 32'h5A5AA5A5, 16'd6, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 32'h0F1E2D3C, 32'h99887766, 1'b0, 1'b0, 32'h0F1E2D3C, 16'd7, 1'b1};

        bus.enable_i = 1'b1;  bus.req0_valid_i = 1'b0;  bus.req1_valid_i = 1'b0;
        bus.req0_data_i = 32'd0;  bus.req1_data_i = 32'd0;
        bus2.enable_i = 1'b1; bus2.req0_valid_i = 1'b0; bus2.req1_valid_i = 1'b0;
        bus2.req0_data_i = 32'd0; bus2.req1_data_i = 32'd0;

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk($sformatf("rst%0d_pclk", s),  32'(m_pclk), 32'd0);
            chk($sformatf("rst%0d_de_n", s),  32'(m_de_n), 32'd1);
            chk($sformatf("rst%0d_data", s),  32'(m_data), 32'd0);
            chk($sformatf("rst%0d_ready", s), 32'(m_r0 | m_r1), 32'd0);
            chk($sformatf("rst%0d_busy", s),  32'(m_busy), 32'd0);
            chk($sformatf("rst%0d_last", s),  32'(m_last), 32'd1);
            chk($sformatf("rst%0d_cnt", s),   32'(m_cnt), 32'd0);
        end
        sel = 0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) send_word(vecs[i], -1);

        drive_en(1'b0);
        drive_v(1'b1, 1'b0, 32'hCAFEF00D, 32'd0);
        check_quiet("enable_low_no_accept", 24);
        drive_en(1'b1);
        sv = '{1'b1, 1'b0, 32'hCAFEF00D, 32'd0, 1'b1, 1'b0, 32'hCAFEF00D, 16'd8, 1'b0};
        send_word(sv, 2);
        check_quiet("enable_dropped_no_accept", 24);
        drive_en(1'b1);
        sv = '{1'b1, 1'b0, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0, 32'hCAFEF00D, 16'd9, 1'b0};
        send_word(sv, -1);

        drive_v(1'b1, 1'b1, 32'h13572468, 32'h24681357);
        wait_accept(got);
        chk("pre_reset_grant", 32'(m_r1), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        repeat (9) @(negedge clk);
        chk("pre_reset_byte1", 32'(m_data), 32'h13);
        chk("pre_reset_de_n", 32'(m_de_n), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_de_n", 32'(m_de_n), 32'd1);
        chk("midrst_data", 32'(m_data), 32'd0);
        chk("midrst_pclk", 32'(m_pclk), 32'd0);
        chk("midrst_busy", 32'(m_busy), 32'd0);
        chk("midrst_cnt", 32'(m_cnt), 32'd0);
        chk("midrst_last", 32'(m_last), 32'd1);
        chk("midrst_ready", 32'(m_r0 | m_r1), 32'd0);
        rst = 1'b0;
        sv = '{1'b1, 1'b1, 32'h13572468, 32'h24681357, 1'b0, 1'b0, 32'h13572468, 16'd1, 1'b0};
        send_word(sv, -1);

        force dut.word_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.word_cnt_q;
        chk("cnt_preload", 32'(m_cnt), 32'h0000FFFF);
        sv = '{1'b1, 1'b0, 32'h00FF55AA, 32'd0, 1'b0, 1'b0, 32'h00FF55AA, 16'h0000, 1'b0};
        send_word(sv, -1);

        sel = 1;
        #1;
        sv = '{1'b1, 1'b1, 32'h77665544, 32'h8899AABB, 1'b1, 1'b0, 32'h77665544, 16'd1, 1'b0};
        send_word(sv, -1);
        sv = '{1'b1, 1'b1, 32'h77665544, 32'h8899AABB, 1'b1, 1'b1, 32'h8899AABB, 16'd2, 1'b1};
        send_word(sv, -1);
        sv = '{1'b1, 1'b1, 32'h77665544, 32'h8899AABB, 1'b0, 1'b0, 32'h77665544, 16'd3, 1'b1};
        send_word(sv, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
